// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if
//   Groups the SPI pins and the byte-RAM port of the flash responder.
//   slave  : the responder side (samples SPI pins, drives MISO and RAM strobes)
//   master : the SPI master plus RAM side (drives SCK/MOSI/CS and read data)
// Signals
//   i_spi_sck, i_spi_mosi, i_spi_cs  SPI pins into the responder (CS active low)
//   o_spi_miso, o_miso_oe            slave-out data and its output enable
//   o_mem_addr, o_mem_re, o_mem_we   RAM address, read and write strobes
//   o_mem_wdata, i_mem_rdata         RAM write / read data (read data 1 clk after re)
//   o_busy                           synchronized "CS is low"
interface spi_flash_responder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  i_spi_sck;
    logic                  i_spi_mosi;
    logic                  i_spi_cs;
    logic                  o_spi_miso;
    logic                  o_miso_oe;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_re;
    logic [7:0]            i_mem_rdata;
    logic                  o_mem_we;
    logic [7:0]            o_mem_wdata;
    logic                  o_busy;

    modport slave (
        input  i_spi_sck,
        input  i_spi_mosi,
        input  i_spi_cs,
        input  i_mem_rdata,
        output o_spi_miso,
        output o_miso_oe,
        output o_mem_addr,
        output o_mem_re,
        output o_mem_we,
        output o_mem_wdata,
        output o_busy
    );

    modport master (
        output i_spi_sck,
        output i_spi_mosi,
        output i_spi_cs,
        output i_mem_rdata,
        input  o_spi_miso,
        input  o_miso_oe,
        input  o_mem_addr,
        input  o_mem_re,
        input  o_mem_we,
        input  o_mem_wdata,
        input  o_busy
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 slave answering the 25-series flash command subset
//   (READ 03, PROGRAM 02, RDSR 05, RDID 9F, WREN 06, WRDI 04) from a
//   single-port byte RAM.
// Ports
//   clk    system clock; SCK must be at most clk/8
//   reset  asynchronous, active low
//   bus    spi_flash_responder_if.slave (SPI pins + RAM port + o_busy)
// Parameters
//   ADDR_WIDTH  RAM address width (> 8); 24-bit SPI addresses keep the low bits
//   JEDEC_ID    three ID bytes returned MSB first by 9F
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | CS high, or waiting for a fresh CS falling edge
// ST_CMD     | shifting in the opcode byte
// ST_ADDR    | shifting in the 3 address bytes
// ST_READ    | streaming RAM bytes out, prefetching one byte ahead
// ST_PROG    | writing each complete received byte, page-wrapped
// ST_STATUS  | repeating the status byte {6'b0, WEL, WIP=0}
// ST_JEDEC   | JEDEC ID bytes, then 00
// ST_IGNORE  | MISO low, no RAM access until CS rises
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4014
) (
    input logic                  clk,
    input logic                  reset,
    spi_flash_responder_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_PROG   = 3'd4;
    localparam logic [2:0] ST_STATUS = 3'd5;
    localparam logic [2:0] ST_JEDEC  = 3'd6;
    localparam logic [2:0] ST_IGNORE = 3'd7;

    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(255);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic sck_meta, sck_sync, sck_prev;
    logic mosi_meta, mosi_sync;
    logic cs_meta, cs_sync, cs_prev;
    logic cs_armed;

    logic [2:0]            state;
    logic [2:0]            bit_cnt;
    logic [6:0]            shift_in;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_read;
    logic                  wel;
    logic [2:0]            tx_cnt;
    logic [7:0]            cur_byte;
    logic [7:0]            rd_buf;
    logic                  rd_pend;
    logic [1:0]            jedec_idx;
    logic                  miso;
    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;

    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    logic [7:0]            byte_in;
    logic                  byte_done;
    logic                  resp_state;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [ADDR_WIDTH-1:0] addr_page_inc;
    logic [7:0]            next_byte;

    // Synchronizer flops reset low so that a CS held low across reset
    // release never looks like a falling edge: cs_armed only sets once
    // CS has actually been seen high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            cs_meta   <= 1'b0;
            cs_sync   <= 1'b0;
            cs_prev   <= 1'b0;
            cs_armed  <= 1'b0;
        end else begin
            sck_meta  <= bus.i_spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= bus.i_spi_mosi;
            mosi_sync <= mosi_meta;
            cs_meta   <= bus.i_spi_cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            cs_armed  <= cs_armed | cs_sync;
        end
    end

    assign sck_rise   = sck_sync & ~sck_prev;
    assign sck_fall   = ~sck_sync & sck_prev;
    assign cs_rise    = cs_sync & ~cs_prev;
    assign cs_fall    = cs_armed & cs_prev & ~cs_sync;
    assign byte_in    = {shift_in, mosi_sync};
    assign byte_done  = sck_rise && (bit_cnt == 3'd7);
    assign resp_state = (state == ST_READ) || (state == ST_STATUS) || (state == ST_JEDEC);

    // Address bytes shift in from the bottom; the shift drops everything
    // above ADDR_WIDTH, which is the truncation of the 24-bit address.
    assign addr_shifted  = (addr << 8) | ADDR_WIDTH'(byte_in);
    assign addr_page_inc = (addr & ~PAGE_MASK) | ((addr + ADDR_ONE) & PAGE_MASK);

    always_comb begin
        next_byte = 8'h00;
        case (state)
            ST_READ:   next_byte = rd_buf;
            ST_STATUS: next_byte = {6'b0, wel, 1'b0};
            ST_JEDEC: begin
                case (jedec_idx)
                    2'd0:    next_byte = JEDEC_ID[23:16];
                    2'd1:    next_byte = JEDEC_ID[15:8];
                    2'd2:    next_byte = JEDEC_ID[7:0];
                    default: next_byte = 8'h00;
                endcase
            end
            default:   next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            byte_cnt  <= 2'd0;
            addr      <= '0;
            is_read   <= 1'b0;
            wel       <= 1'b0;
            tx_cnt    <= 3'd0;
            cur_byte  <= 8'h00;
            rd_buf    <= 8'h00;
            rd_pend   <= 1'b0;
            jedec_idx <= 2'd0;
            miso      <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            // RAM data is valid the clk after the read strobe.
            rd_pend <= mem_re;
            if (rd_pend) begin
                rd_buf <= bus.i_mem_rdata;
            end

            if (cs_rise) begin
                if (state == ST_PROG) begin
                    wel <= 1'b0;
                end
                state <= ST_IDLE;
                miso  <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (cs_fall) begin
                    state     <= ST_CMD;
                    bit_cnt   <= 3'd0;
                    byte_cnt  <= 2'd0;
                    addr      <= '0;
                    tx_cnt    <= 3'd0;
                    jedec_idx <= 2'd0;
                end
            end else begin
                if (sck_rise) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            byte_cnt <= 2'd0;
                            case (byte_in)
                                8'h03: begin
                                    state   <= ST_ADDR;
                                    is_read <= 1'b1;
                                end
                                8'h02: begin
                                    is_read <= 1'b0;
                                    state   <= wel ? ST_ADDR : ST_IGNORE;
                                end
                                8'h05:   state <= ST_STATUS;
                                8'h9F:   state <= ST_JEDEC;
                                8'h06: begin
                                    wel   <= 1'b1;
                                    state <= ST_IGNORE;
                                end
                                8'h04: begin
                                    wel   <= 1'b0;
                                    state <= ST_IGNORE;
                                end
                                default: state <= ST_IGNORE;
                            endcase
                        end
                        ST_ADDR: begin
                            addr <= addr_shifted;
                            if (byte_cnt == 2'd2) begin
                                if (is_read) begin
                                    state    <= ST_READ;
                                    mem_re   <= 1'b1;
                                    mem_addr <= addr_shifted;
                                end else begin
                                    state <= ST_PROG;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                        ST_PROG: begin
                            mem_we    <= 1'b1;
                            mem_wdata <= byte_in;
                            mem_addr  <= addr;
                            addr      <= addr_page_inc;
                        end
                        default: ;
                    endcase
                end

                // tx_cnt == 0 marks the fall that drives bit 7 of a new
                // byte; READ fetches the following byte at the same time so
                // it is in rd_buf well before the next byte boundary.
                if (sck_fall && resp_state) begin
                    tx_cnt <= tx_cnt + 3'd1;
                    if (tx_cnt == 3'd0) begin
                        cur_byte <= next_byte;
                        miso     <= next_byte[7];
                        if (state == ST_READ) begin
                            addr     <= addr + ADDR_ONE;
                            mem_addr <= addr + ADDR_ONE;
                            mem_re   <= 1'b1;
                        end
                        if ((state == ST_JEDEC) && (jedec_idx != 2'd3)) begin
                            jedec_idx <= jedec_idx + 2'd1;
                        end
                    end else begin
                        miso <= cur_byte[3'd7 - tx_cnt];
                    end
                end
            end
        end
    end

    assign bus.o_spi_miso  = miso;
    assign bus.o_miso_oe   = resp_state;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_re    = mem_re;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_busy      = cs_armed & ~cs_sync;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder
//   Directed bench: plays SPI master (SCK = clk/16) and a synchronous byte
//   RAM, and checks read data, write strobes, status and ID bytes against
//   hand-computed values.
module tb_spi_flash_responder;
    localparam int AW   = 12;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_flash_responder_if #(.ADDR_WIDTH(AW)) bus ();

    spi_flash_responder #(
        .ADDR_WIDTH(AW),
        .JEDEC_ID  (24'hEF4014)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [7:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr];
        if (bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_wdata;
    end

    int re_cnt = 0;
    int we_cnt = 0;
    int both_cnt = 0;
    logic [AW-1:0] wr_addr_q [$];
    logic [7:0]    wr_data_q [$];

    always @(negedge clk) begin
        if (bus.o_mem_re) re_cnt++;
        if (bus.o_mem_we) begin
            we_cnt++;
            wr_addr_q.push_back(bus.o_mem_addr);
            wr_data_q.push_back(bus.o_mem_wdata);
        end
        if (bus.o_mem_re && bus.o_mem_we) both_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.i_spi_mosi = tx[i];
            clk_wait(HALF);
            rx[i] = bus.o_spi_miso;
            bus.i_spi_sck = 1'b1;
            clk_wait(HALF);
            bus.i_spi_sck = 1'b0;
        end
    endtask

    task automatic tx_byte(input logic [7:0] b);
        logic [7:0] dummy;
        spi_xfer(b, 8, dummy);
    endtask

    task automatic cs_begin();
        bus.i_spi_cs = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic cs_end();
        clk_wait(HALF);
        bus.i_spi_cs = 1'b1;
        clk_wait(2 * HALF);
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        cs_begin();
        tx_byte(op);
        cs_end();
    endtask

    task automatic read_status(output logic [7:0] s0, output logic [7:0] s1);
        cs_begin();
        tx_byte(8'h05);
        spi_xfer(8'h00, 8, s0);
        spi_xfer(8'h00, 8, s1);
        cs_end();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d0, d1, d2, d3;
        int r0, r1, w0;

        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'(a * 7 + 1);
        mem[12'h123] = 8'hA5;
        mem[12'h124] = 8'h5A;
        mem[12'hFFF] = 8'h3C;
        mem[12'h000] = 8'hC3;
        mem[12'h010] = 8'h77;
        mem[12'h020] = 8'h55;

        reset = 1'b0;
        bus.i_spi_cs   = 1'b1;
        bus.i_spi_sck  = 1'b0;
        bus.i_spi_mosi = 1'b0;
        clk_wait(3);
        check("rst_strobes", {bus.o_spi_miso, bus.o_miso_oe, bus.o_mem_re, bus.o_mem_we, bus.o_busy}, 0);
        check("rst_addr", 32'(bus.o_mem_addr), 0);
        check("rst_wdata", 32'(bus.o_mem_wdata), 0);
        reset = 1'b1;
        clk_wait(4);

        // READ 0x123: A5 then 5A; 2 prefetch strobes while 16 bits are clocked
        cs_begin();
        tx_byte(8'h03); tx_byte(8'h00); tx_byte(8'h01); tx_byte(8'h23);
        clk_wait(6);
        r0 = re_cnt;
        spi_xfer(8'h00, 8, d0);
        spi_xfer(8'h00, 8, d1);
        clk_wait(6);
        r1 = re_cnt;
        check("read_oe", 32'(bus.o_miso_oe), 1);
        check("read_busy", 32'(bus.o_busy), 1);
        cs_end();
        check("read_b0", 32'(d0), 32'hA5);
        check("read_b1", 32'(d1), 32'h5A);
        check("read_re_pulses", 32'(r1 - r0), 2);
        check("oe_after_cs", 32'(bus.o_miso_oe), 0);

        // READ wrap 0xFFF -> 0x000
        cs_begin();
        tx_byte(8'h03); tx_byte(8'h00); tx_byte(8'h0F); tx_byte(8'hFF);
        spi_xfer(8'h00, 8, d0);
        spi_xfer(8'h00, 8, d1);
        cs_end();
        check("wrap_b0", 32'(d0), 32'h3C);
        check("wrap_b1", 32'(d1), 32'hC3);

        // PROGRAM without WREN is ignored
        w0 = we_cnt;
        cs_begin();
        tx_byte(8'h02); tx_byte(8'h00); tx_byte(8'h00); tx_byte(8'h10);
        tx_byte(8'h11); tx_byte(8'h22);
        cs_end();
        check("prog_no_wren_we", 32'(we_cnt - w0), 0);
        check("prog_no_wren_mem", 32'(mem[12'h010]), 32'h77);

        // WREN + PROGRAM across the page end
        one_byte_cmd(8'h06);
        wr_addr_q.delete();
        wr_data_q.delete();
        w0 = we_cnt;
        cs_begin();
        tx_byte(8'h02); tx_byte(8'h00); tx_byte(8'h00); tx_byte(8'hFE);
        tx_byte(8'h11); tx_byte(8'h22); tx_byte(8'h33);
        cs_end();
        check("prog_we_count", 32'(we_cnt - w0), 3);
        check("prog_w0", {wr_addr_q[0], wr_data_q[0]}, {12'h0FE, 8'h11});
        check("prog_w1", {wr_addr_q[1], wr_data_q[1]}, {12'h0FF, 8'h22});
        check("prog_w2", {wr_addr_q[2], wr_data_q[2]}, {12'h000, 8'h33});
        check("prog_mem_100_kept", 32'(mem[12'h100]), 32'(8'(12'h100 * 7 + 1)));
        read_status(d0, d1);
        check("wel_after_prog", 32'(d0), 32'h00);

        // status with WEL set / cleared
        one_byte_cmd(8'h06);
        read_status(d0, d1);
        check("status_wel", 32'(d0), 32'h02);
        check("status_repeat", 32'(d1), 32'h02);
        one_byte_cmd(8'h04);
        read_status(d0, d1);
        check("status_wrdi", 32'(d0), 32'h00);

        // JEDEC ID
        cs_begin();
        tx_byte(8'h9F);
        spi_xfer(8'h00, 8, d0);
        spi_xfer(8'h00, 8, d1);
        spi_xfer(8'h00, 8, d2);
        spi_xfer(8'h00, 8, d3);
        cs_end();
        check("jedec", {d0, d1, d2, d3}, 32'hEF401400);

        // aborted PROGRAM: 5 data bits then CS high
        one_byte_cmd(8'h06);
        w0 = we_cnt;
        cs_begin();
        tx_byte(8'h02); tx_byte(8'h00); tx_byte(8'h00); tx_byte(8'h20);
        spi_xfer(8'hAA, 5, d0);
        cs_end();
        check("abort_we", 32'(we_cnt - w0), 0);
        check("abort_mem", 32'(mem[12'h020]), 32'h55);
        read_status(d0, d1);
        check("abort_wel", 32'(d0), 32'h00);

        // reset in the middle of a READ
        one_byte_cmd(8'h06);
        cs_begin();
        tx_byte(8'h03); tx_byte(8'h00); tx_byte(8'h01); tx_byte(8'h23);
        spi_xfer(8'h00, 4, d0);
        clk_wait(6);
        check("midread_oe", 32'(bus.o_miso_oe), 1);
        reset = 1'b0;
        #1;
        check("midrst_strobes", {bus.o_spi_miso, bus.o_miso_oe, bus.o_mem_re, bus.o_mem_we, bus.o_busy}, 0);
        check("midrst_addr", 32'(bus.o_mem_addr), 0);
        check("midrst_wdata", 32'(bus.o_mem_wdata), 0);
        r0 = re_cnt;
        w0 = we_cnt;
        clk_wait(3);
        reset = 1'b1;
        spi_xfer(8'h00, 8, d0);
        cs_end();
        check("postrst_no_strobes", 32'((re_cnt - r0) + (we_cnt - w0)), 0);
        read_status(d0, d1);
        check("postrst_wel", 32'(d0), 32'h00);

        // recovery READ after reset
        cs_begin();
        tx_byte(8'h03); tx_byte(8'h00); tx_byte(8'h01); tx_byte(8'h24);
        spi_xfer(8'h00, 8, d0);
        cs_end();
        check("postrst_read", 32'(d0), 32'h5A);

        check("re_we_overlap", 32'(both_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI mode-0 slave that emulates the command subset of a 25-series serial flash, backed by an on-FPGA byte memory. It answers the same READ/PROGRAM/STATUS/ID traffic that the flash controller and flash writer issue as SPI masters. That lets the 6809 ROM window at 0xF000–0xFFFF run against on-chip EBR instead of the external flash, and gives the bench a synthesizable flash model. It sits between the SPI master mux and a single-port byte RAM.

## Interface
- ADDR_WIDTH, 12, memory address width; 24-bit SPI addresses are truncated to the low ADDR_WIDTH bits
- JEDEC_ID, 24'hEF4014, bytes returned MSB first by command 0x9F
- clk  in  1  system clock (8 MHz domain); SCK must be ≤ clk/8
- reset  in  1  asynchronous, active-low
- i_spi_sck  in  1  SPI clock, asynchronous to clk
- i_spi_mosi  in  1  master-out data, asynchronous
- i_spi_cs  in  1  chip select, active low, asynchronous
- o_spi_miso  out  1  slave-out data
- o_miso_oe  out  1  high while CS is low and a response phase is active
- o_mem_addr  out  ADDR_WIDTH  RAM address
- o_mem_re  out  1  one-cycle read strobe; i_mem_rdata is valid on the next clk
- i_mem_rdata  in  8  RAM read data
- o_mem_we  out  1  one-cycle write strobe
- o_mem_wdata  out  8  RAM write data
- o_busy  out  1  high while CS is low (synchronized)

## Operation
- Synchronizers: SCK, MOSI and CS each pass through a 2-FF synchronizer. Edges are detected on the synchronized SCK: rise samples MOSI, fall shifts MISO.
- Shift-in: an 8-bit register, MSB first, with a 3-bit bit counter. A byte completes on the 8th rise.
- States: IDLE, CMD, ADDR, READ, PROG, STATUS, JEDEC, IGNORE.
- IDLE→CMD: on the CS falling edge. Bit counter and address counter are cleared.
- CMD: on byte completion, decode the opcode:
  - 0x03 or 0x02 (0x02 only with WEL=1) → ADDR, byte count 0.
  - 0x05 → STATUS.
  - 0x9F → JEDEC.
  - 0x06: set WEL → IGNORE.
  - 0x04: clear WEL → IGNORE.
  - 0x02 with WEL=0, or any other opcode → IGNORE.
- ADDR: collect 3 bytes into a 24-bit address, keeping the low ADDR_WIDTH bits. After the 3rd byte:
  - READ opcode: pulse o_mem_re at that address → READ.
  - PROG opcode: → PROG.
- READ:
  - The fetched byte loads the shift-out register before the next SCK fall.
  - On the fall that drives bit 7 of the current byte, increment the address and pulse o_mem_re to prefetch the next byte.
  - Bytes stream until CS rises. The address wraps from 2^ADDR_WIDTH−1 to 0.
- PROG:
  - Each completed byte → o_mem_we for one clk, with o_mem_wdata = the byte and o_mem_addr = the current address.
  - The address then increments within its 256-byte page: the low 8 bits wrap, the upper bits are unchanged.
  - A byte is never written unless all 8 bits were received.
- STATUS: shift out {6'b0, WEL, 1'b0} repeatedly until CS rises. WIP always reads 0.
- JEDEC: shift out JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 thereafter.
- IGNORE: MISO=0 and no memory access until CS rises.
- CS rise, from any state → IDLE:
  - All in-progress counters are discarded.
  - WEL is cleared if the frame was a PROG frame that reached PROG.
- Reset mid-frame: go to IDLE, clear WEL, and issue no memory strobes until the next CS falling edge.

## Timing
- Reset values:
  - o_spi_miso=0, o_miso_oe=0, o_mem_re=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0.
  - State=IDLE, WEL=0.
- Edge latency: internal action follows the pin edge by 3 clk (2 sync + 1 detect).
- MISO after a SCK fall: o_spi_miso updates at most 4 clk after the pin edge, which meets the next rise at SCK ≤ clk/8.
- READ first byte:
  - o_mem_re asserts 1 clk after the 24th address bit is detected.
  - The data is loaded 2 clk later, ahead of the first response SCK fall.
- o_miso_oe rises on entry to READ/STATUS/JEDEC and falls 3 clk after the CS rise at the pin.
- o_mem_we is exactly 1 clk wide per programmed byte.
- o_mem_re and o_mem_we are never high in the same cycle.

## Test plan
- READ: RAM[0x123]=0xA5, RAM[0x124]=0x5A; send 03 00 01 23, then clock 16 bits → MISO returns A5 then 5A, with exactly 2 o_mem_re pulses.
- READ wrap: READ at 0x000FFF with ADDR_WIDTH=12, clocking 2 bytes → returns RAM[0xFFF], then RAM[0x000].
- Program-enable gating:
  - 02 00 00 10 11 22 without WREN → no o_mem_we.
  - 06, then 02 00 00 FE 11 22 33 → writes 11@0x0FE, 22@0x0FF, 33@0x000 (page wrap).
  - A following 05 returns 0x00 (WEL cleared).
- Status and ID: 06, then 05 → 0x02; 04, then 05 → 0x00; 9F with 32 SCKs → EF 40 14 00.
- Abort: 06, then 02 00 00 20 and 5 bits, then CS high → no write, WEL cleared; reset asserted mid-READ → all outputs return to reset values immediately.
